buffer_m1_stream_ctrl: RTL and testbench

- Drives the mode-1 control bundle of the buffer banks: per-bank read enables/addresses and per-bank write enables/addresses.
- Streams a tile of LEN words from every selected bank into the PE array, then writes the PE results back after a fixed pipeline lag.
- Sits between the layer sequencer (start/config) and the buffer bank array. It is the initiator end of the m1 control bundle.

---
 rtl/buffer_m1_stream_ctrl.sv | 294 +++++++++++++++++++++++++++++
 tb/tb_buffer_m1_stream_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/buffer_m1_stream_ctrl.sv
// ---------------------------------------------------------------------------
// buffer_m1_stream_ctrl
//
// Initiator of the mode-1 control bundle towards the buffer bank array.
// On an accepted start it streams LEN read beats out of every selected bank
// into the PE array, then writes the PE results back WR_LAG advancing cycles
// after each read. It finishes with a one-cycle done pulse.
//
// Optional build macro: BUF_M1_SKEW_EN
//   Defined     : systolic skew. Bank i sees its read and write beats i extra
//                 advancing cycles after bank 0. The completion waits for the
//                 last write of bank N_BUF-1.
//   Not defined : all banks share the same beat timing and no skew
//                 registers exist.
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   start        single-cycle request, sampled only in IDLE
//   bank_mask    participating banks            (latched at start)
//   rd_base      first read address             (latched at start)
//   wr_base      first write address            (latched at start)
//   len          beats to stream, 0..2^ADDR_RAM (latched at start)
//   stall        PE back-pressure; freezes all progress for that cycle
//   m1_r_en      per-bank read enable
//   m1_r_addr    per-bank read address  (unpacked, one entry per bank)
//   m1_w_en      per-bank write enable
//   m1_w_addr    per-bank write address (unpacked, one entry per bank)
//   busy         high from the cycle after an accepted start until done
//   done         one-cycle completion pulse
// ---------------------------------------------------------------------------
module buffer_m1_stream_ctrl #(
   parameter int N_BUF    = 8,
   parameter int ADDR_RAM = 10,
   parameter int WR_LAG   = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [N_BUF-1:0]    bank_mask,
   input  logic [ADDR_RAM-1:0] rd_base,
   input  logic [ADDR_RAM-1:0] wr_base,
   input  logic [ADDR_RAM:0]   len,
   input  logic                stall,
   output logic [N_BUF-1:0]    m1_r_en,
   output logic [ADDR_RAM-1:0] m1_r_addr [N_BUF],
   output logic [N_BUF-1:0]    m1_w_en,
   output logic [ADDR_RAM-1:0] m1_w_addr [N_BUF],
   output logic                busy,
   output logic                done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [ADDR_RAM:0]   LEN_ONE  = {{ADDR_RAM{1'b0}}, 1'b1};
   localparam logic [ADDR_RAM-1:0] ADDR_ONE = {{(ADDR_RAM-1){1'b0}}, 1'b1};

   state_t              state_r;
   state_t              state_s;

   // Configuration latched at start
   logic [N_BUF-1:0]    mask_r;
   logic [ADDR_RAM-1:0] wr_base_r;
   logic [ADDR_RAM:0]   len_r;

   // Read beat currently presented (index rc_r), write counter
   logic                r_vld_r;
   logic [ADDR_RAM-1:0] r_addr_r;
   logic [ADDR_RAM:0]   rc_r;
   logic [ADDR_RAM:0]   wc_r;

   // Lag pipe: bit j set means a read beat issued j+1 advancing cycles ago.
   // The last stage is the write beat currently presented.
   logic [WR_LAG-1:0]   pipe_r;
   logic [WR_LAG:0]     chain_s;
   logic [ADDR_RAM-1:0] w_addr_r;
   logic                w_last_r;

   logic                busy_r;
   logic                done_r;

   logic                adv_s;
   logic                r_issue_s;
   logic                r_last_s;
   logic                w_load_s;
   logic                w_done_s;

   // Per-bank view of the beat stream; stage i drives bank i
   logic                rs_vld_s  [N_BUF];
   logic [ADDR_RAM-1:0] rs_addr_s [N_BUF];
   logic                ws_vld_s  [N_BUF];
   logic [ADDR_RAM-1:0] ws_addr_s [N_BUF];
   logic                ws_last_s [N_BUF];

   // Progress qualifiers shared by the FSM and the datapath
   always_comb begin
      adv_s     = ~stall;
      chain_s   = {pipe_r, r_vld_r};
      r_issue_s = r_vld_r & adv_s;
      r_last_s  = r_issue_s & (rc_r == (len_r - LEN_ONE));
      // A beat enters the last pipe stage: it becomes the next write beat
      w_load_s  = adv_s & chain_s[WR_LAG-1];
      // The final write of the slowest bank retires
      w_done_s  = adv_s & ws_vld_s[N_BUF-1] & ws_last_s[N_BUF-1];
   end

   // Next-state logic
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               if (len != {(ADDR_RAM+1){1'b0}}) begin
                  state_s = READ;
               end else begin
                  state_s = DONE;
               end
            end else begin
               state_s = IDLE;
            end
         end
         READ: begin
            if (r_last_s) begin
               state_s = DRAIN;
            end else begin
               state_s = READ;
            end
         end
         DRAIN: begin
            if (w_done_s) begin
               state_s = DONE;
            end else begin
               state_s = DRAIN;
            end
         end
         DONE:    state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Configuration capture on an accepted start
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mask_r    <= {N_BUF{1'b0}};
         wr_base_r <= {ADDR_RAM{1'b0}};
         len_r     <= {(ADDR_RAM+1){1'b0}};
      end else if ((state_r == IDLE) && start) begin
         mask_r    <= bank_mask;
         wr_base_r <= wr_base;
         len_r     <= len;
      end
   end

   // Read beat generator: beat 0 is loaded at accept, later beats on issue
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld_r  <= 1'b0;
         r_addr_r <= {ADDR_RAM{1'b0}};
         rc_r     <= {(ADDR_RAM+1){1'b0}};
      end else if ((state_r == IDLE) && start && (len != {(ADDR_RAM+1){1'b0}})) begin
         r_vld_r  <= 1'b1;
         r_addr_r <= rd_base;
         rc_r     <= {(ADDR_RAM+1){1'b0}};
      end else if (r_last_s) begin
         // Address is held so the bus never shows a fresh value after the end
         r_vld_r  <= 1'b0;
      end else if (r_issue_s) begin
         r_addr_r <= r_addr_r + ADDR_ONE;
         rc_r     <= rc_r + LEN_ONE;
      end
   end

   // Lag pipe, advancing only on non-stalled cycles
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pipe_r <= {WR_LAG{1'b0}};
      end else if (adv_s) begin
         pipe_r <= chain_s[WR_LAG-1:0];
      end
   end

   // Write beat address/last tracking as beats enter the last pipe stage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_addr_r <= {ADDR_RAM{1'b0}};
         w_last_r <= 1'b0;
         wc_r     <= {(ADDR_RAM+1){1'b0}};
      end else if ((state_r == IDLE) && start) begin
         wc_r     <= {(ADDR_RAM+1){1'b0}};
      end else if (w_load_s) begin
         w_addr_r <= wr_base_r + wc_r[ADDR_RAM-1:0];
         w_last_r <= (wc_r == (len_r - LEN_ONE));
         wc_r     <= wc_r + LEN_ONE;
      end
   end

   // Registered status outputs follow the next state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_r <= 1'b0;
         done_r <= 1'b0;
      end else begin
         busy_r <= (state_s == READ) || (state_s == DRAIN);
         done_r <= (state_s == DONE);
      end
   end

`ifdef BUF_M1_SKEW_EN
   // Skew delay lines; stage i (i>=1) is stage i-1 one advancing cycle later
   logic                rk_vld_r  [1:N_BUF-1];
   logic [ADDR_RAM-1:0] rk_addr_r [1:N_BUF-1];
   logic                wk_vld_r  [1:N_BUF-1];
   logic [ADDR_RAM-1:0] wk_addr_r [1:N_BUF-1];
   logic                wk_last_r [1:N_BUF-1];

   // Stage 0 is the unskewed beat; higher stages come from the delay lines
   always_comb begin
      rs_vld_s[0]  = r_vld_r;
      rs_addr_s[0] = r_addr_r;
      ws_vld_s[0]  = pipe_r[WR_LAG-1];
      ws_addr_s[0] = w_addr_r;
      ws_last_s[0] = w_last_r;
      for (int i = 1; i < N_BUF; i++) begin
         rs_vld_s[i]  = rk_vld_r[i];
         rs_addr_s[i] = rk_addr_r[i];
         ws_vld_s[i]  = wk_vld_r[i];
         ws_addr_s[i] = wk_addr_r[i];
         ws_last_s[i] = wk_last_r[i];
      end
   end

   // Delay-line shift on advancing cycles
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 1; i < N_BUF; i++) begin
            rk_vld_r[i]  <= 1'b0;
            rk_addr_r[i] <= {ADDR_RAM{1'b0}};
            wk_vld_r[i]  <= 1'b0;
            wk_addr_r[i] <= {ADDR_RAM{1'b0}};
            wk_last_r[i] <= 1'b0;
         end
      end else if (adv_s) begin
         for (int i = 1; i < N_BUF; i++) begin
            rk_vld_r[i]  <= rs_vld_s[i-1];
            rk_addr_r[i] <= rs_addr_s[i-1];
            wk_vld_r[i]  <= ws_vld_s[i-1];
            wk_addr_r[i] <= ws_addr_s[i-1];
            wk_last_r[i] <= ws_last_s[i-1];
         end
      end
   end
`else
   // Every bank shares the unskewed beat
   always_comb begin
      for (int i = 0; i < N_BUF; i++) begin
         rs_vld_s[i]  = r_vld_r;
         rs_addr_s[i] = r_addr_r;
         ws_vld_s[i]  = pipe_r[WR_LAG-1];
         ws_addr_s[i] = w_addr_r;
         ws_last_s[i] = w_last_r;
      end
   end
`endif

   // Bus drive: enables are masked per bank and dropped in a stalled cycle,
   // addresses stay at their registered value
   always_comb begin
      m1_r_en = {N_BUF{1'b0}};
      m1_w_en = {N_BUF{1'b0}};
      for (int i = 0; i < N_BUF; i++) begin
         m1_r_en[i]   = rs_vld_s[i] & mask_r[i] & adv_s;
         m1_r_addr[i] = rs_addr_s[i];
         m1_w_en[i]   = ws_vld_s[i] & mask_r[i] & adv_s;
         m1_w_addr[i] = ws_addr_s[i];
      end
   end

   assign busy = busy_r;
   assign done = done_r;

endmodule

// File: tb/tb_buffer_m1_stream_ctrl.sv
// Self-checking bench for buffer_m1_stream_ctrl. A timing model computes the
// cycle and address of every expected per-bank beat at start time and pushes
// them to per-bank queues; each cycle the observed enables pop and compare.
module tb_buffer_m1_stream_ctrl;

   localparam int N   = 8;
   localparam int A   = 10;
   localparam int LAG = 4;
`ifdef BUF_M1_SKEW_EN
   localparam int SKEW = 1;
`else
   localparam int SKEW = 0;
`endif

   logic           clk = 1'b0;
   logic           rst_n;
   logic           start;
   logic [N-1:0]   bank_mask;
   logic [A-1:0]   rd_base;
   logic [A-1:0]   wr_base;
   logic [A:0]     len;
   logic           stall;
   logic [N-1:0]   m1_r_en;
   logic [A-1:0]   m1_r_addr [N];
   logic [N-1:0]   m1_w_en;
   logic [A-1:0]   m1_w_addr [N];
   logic           busy;
   logic           done;

   buffer_m1_stream_ctrl #(.N_BUF(N), .ADDR_RAM(A), .WR_LAG(LAG)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .bank_mask(bank_mask),
      .rd_base(rd_base), .wr_base(wr_base), .len(len), .stall(stall),
      .m1_r_en(m1_r_en), .m1_r_addr(m1_r_addr), .m1_w_en(m1_w_en),
      .m1_w_addr(m1_w_addr), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct {
      int           cyc;
      logic [A-1:0] addr;
   } ev_t;

   ev_t rq [N][$];
   ev_t wq [N][$];

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int st_from = -1;
   int st_to = -1;
   int exp_done = -1;
   int bz_lo = 1;
   int bz_hi = 0;
   bit done_seen = 1'b0;

   function automatic bit stalled(int c);
      return (c >= st_from) && (c < st_to);
   endfunction

   function automatic int next_issue(int c);
      int x = c;
      while (stalled(x)) x++;
      return x;
   endfunction

   // Cycle at which a beat issued at c reappears after n advancing cycles
   function automatic int after_adv(int c, int n);
      int x = c;
      for (int j = 0; j < n; j++) begin
         x = next_issue(x);
         x++;
      end
      return next_issue(x);
   endfunction

   function automatic int leftover();
      int n = 0;
      for (int i = 0; i < N; i++) n += rq[i].size() + wq[i].size();
      return n;
   endfunction

   // One clock: advance, drive stall for the new cycle, then score outputs
   task automatic step();
      ev_t e;
      logic exp_b;
      @(posedge clk);
      cyc++;
      #1 stall = stalled(cyc);
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
         if (m1_r_en[i]) begin
            n_cmp++;
            if (rq[i].size() == 0) begin
               n_bad++;
               $display("FAIL rd_beat bank %0d cyc %0d: got read addr %0d, required no read", i, cyc, m1_r_addr[i]);
            end else begin
               e = rq[i].pop_front();
               if (e.cyc != cyc || e.addr !== m1_r_addr[i]) begin
                  n_bad++;
                  $display("FAIL rd_beat bank %0d: got cyc %0d addr %0d, required cyc %0d addr %0d", i, cyc, m1_r_addr[i], e.cyc, e.addr);
               end
            end
         end
         if (m1_w_en[i]) begin
            n_cmp++;
            if (wq[i].size() == 0) begin
               n_bad++;
               $display("FAIL wr_beat bank %0d cyc %0d: got write addr %0d, required no write", i, cyc, m1_w_addr[i]);
            end else begin
               e = wq[i].pop_front();
               if (e.cyc != cyc || e.addr !== m1_w_addr[i]) begin
                  n_bad++;
                  $display("FAIL wr_beat bank %0d: got cyc %0d addr %0d, required cyc %0d addr %0d", i, cyc, m1_w_addr[i], e.cyc, e.addr);
               end
            end
         end
      end
      if (done) begin
         n_cmp++;
         if (cyc != exp_done) begin
            n_bad++;
            $display("FAIL done_time: got done at cyc %0d, required cyc %0d", cyc, exp_done);
         end else begin
            done_seen = 1'b1;
         end
      end
      exp_b = (cyc >= bz_lo) && (cyc <= bz_hi);
      n_cmp++;
      if (busy !== exp_b) begin
         n_bad++;
         $display("FAIL busy cyc %0d: got %b, required %b", cyc, busy, exp_b);
      end
   endtask

   // Drive a start and push the modelled beats of the whole transfer
   task automatic launch(logic [N-1:0] m, logic [A-1:0] rb, logic [A-1:0] wb, logic [A:0] ln);
      int  s = cyc;
      int  rt = cyc;
      int  wt;
      int  lastw = cyc;
      ev_t e;
      bank_mask = m; rd_base = rb; wr_base = wb; len = ln; start = 1'b1;
      done_seen = 1'b0;
      for (int k = 0; k < int'(ln); k++) begin
         rt = next_issue(rt + 1);
         wt = after_adv(rt, LAG);
         for (int i = 0; i < N; i++) begin
            if (m[i]) begin
               e.cyc = after_adv(rt, i * SKEW); e.addr = rb + k[A-1:0];
               rq[i].push_back(e);
               e.cyc = after_adv(wt, i * SKEW); e.addr = wb + k[A-1:0];
               wq[i].push_back(e);
            end
         end
         lastw = after_adv(wt, (N - 1) * SKEW);
      end
      exp_done = lastw + 1;
      bz_lo = s + 1;
      bz_hi = lastw;
      step();
      start = 1'b0;
      // Scramble the inputs: the transfer must run on the latched copy
      bank_mask = ~m; rd_base = ~rb; wr_base = ~wb; len = 11'd3;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; stall = 1'b0;
      bank_mask = '0; rd_base = '0; wr_base = '0; len = '0;
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         n_cmp++;
         if (m1_r_addr[i] !== '0 || m1_w_addr[i] !== '0) begin
            n_bad++;
            $display("FAIL reset_addr bank %0d: got r %0d w %0d, required 0", i, m1_r_addr[i], m1_w_addr[i]);
         end
      end
      n_cmp++;
      if (m1_r_en !== '0 || m1_w_en !== '0 || busy !== 1'b0 || done !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_ctrl: got r_en %h w_en %h busy %b done %b, required all 0", m1_r_en, m1_w_en, busy, done);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) step();
   endtask

   task automatic test_basic();
      launch(8'hFF, 10'd10, 10'd100, 11'd5);
      repeat (exp_done - cyc + 2) step();
      n_cmp++;
      if (leftover() != 0 || !done_seen) begin
         n_bad++;
         $display("FAIL basic_end: got %0d beats missing, done_seen %0d, required 0 and 1", leftover(), done_seen);
      end
   endtask

   task automatic test_stall();
      int s = cyc;
      st_from = s + 3;
      st_to   = s + 5;
      launch(8'hFF, 10'd10, 10'd100, 11'd5);
      repeat (exp_done - cyc + 2) begin
         step();
         if (cyc == s + 3 || cyc == s + 4) begin
            n_cmp++;
            if (m1_r_en !== '0 || m1_w_en !== '0 || m1_r_addr[0] !== 10'd12) begin
               n_bad++;
               $display("FAIL stall_hold cyc %0d: got r_en %h w_en %h addr %0d, required 0 0 12", cyc, m1_r_en, m1_w_en, m1_r_addr[0]);
            end
         end
      end
      st_from = -1;
      st_to = -1;
      n_cmp++;
      if (leftover() != 0 || !done_seen) begin
         n_bad++;
         $display("FAIL stall_end: got %0d beats missing, done_seen %0d, required 0 and 1", leftover(), done_seen);
      end
   endtask

   task automatic test_wrap_mask();
      launch(8'h05, 10'd1022, 10'd1021, 11'd4);
      repeat (exp_done - cyc + 2) step();
      n_cmp++;
      if (leftover() != 0 || !done_seen) begin
         n_bad++;
         $display("FAIL wrap_end: got %0d beats missing, done_seen %0d, required 0 and 1", leftover(), done_seen);
      end
      // Full address space: every address once, both counters wrap
      launch(8'h01, 10'd5, 10'd1000, 11'd1024);
      repeat (exp_done - cyc + 2) step();
      n_cmp++;
      if (leftover() != 0 || !done_seen) begin
         n_bad++;
         $display("FAIL full_len_end: got %0d beats missing, done_seen %0d, required 0 and 1", leftover(), done_seen);
      end
   endtask

   task automatic test_zero_and_ignored();
      // len==0: done right after start, no enables; a start in DONE is dropped
      launch(8'hFF, 10'd10, 10'd100, 11'd0);
      bank_mask = 8'hFF; rd_base = 10'd300; len = 11'd3; start = 1'b1;
      step();
      start = 1'b0;
      repeat (6) step();
      n_cmp++;
      if (leftover() != 0 || !done_seen) begin
         n_bad++;
         $display("FAIL zero_len_end: got %0d beats missing, done_seen %0d, required 0 and 1", leftover(), done_seen);
      end
      // Start while busy must not disturb the running transfer
      launch(8'h3C, 10'd40, 10'd60, 11'd6);
      repeat (2) step();
      bank_mask = 8'hFF; rd_base = 10'd500; len = 11'd7; start = 1'b1;
      step();
      start = 1'b0;
      repeat (exp_done - cyc + 4) step();
      n_cmp++;
      if (leftover() != 0 || !done_seen) begin
         n_bad++;
         $display("FAIL busy_start_end: got %0d beats missing, done_seen %0d, required 0 and 1", leftover(), done_seen);
      end
   endtask

   task automatic test_reset_mid();
      int s = cyc;
      launch(8'hFF, 10'd10, 10'd100, 11'd5);
      while (cyc < s + 7) step();
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (m1_r_en !== '0 || m1_w_en !== '0 || busy !== 1'b0 || done !== 1'b0 ||
          m1_w_addr[3] !== '0 || m1_r_addr[5] !== '0) begin
         n_bad++;
         $display("FAIL reset_mid: got r_en %h w_en %h busy %b done %b waddr %0d raddr %0d, required all 0",
                  m1_r_en, m1_w_en, busy, done, m1_w_addr[3], m1_r_addr[5]);
      end
      for (int i = 0; i < N; i++) begin
         rq[i].delete();
         wq[i].delete();
      end
      exp_done = -1;
      bz_lo = 1;
      bz_hi = 0;
      repeat (2) step();
      rst_n = 1'b1;
      repeat (3) step();
      launch(8'hA5, 10'd200, 10'd7, 11'd3);
      repeat (exp_done - cyc + 2) step();
      n_cmp++;
      if (leftover() != 0 || !done_seen) begin
         n_bad++;
         $display("FAIL after_reset_end: got %0d beats missing, done_seen %0d, required 0 and 1", leftover(), done_seen);
      end
   endtask

`ifdef BUF_M1_SKEW_EN
   task automatic test_skew();
      launch(8'hFF, 10'd3, 10'd200, 11'd2);
      repeat (exp_done - cyc + 2) step();
      n_cmp++;
      if (leftover() != 0 || !done_seen) begin
         n_bad++;
         $display("FAIL skew_end: got %0d beats missing, done_seen %0d, required 0 and 1", leftover(), done_seen);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_wrap_mask();
      test_zero_and_ignored();
      test_reset_mid();
`ifdef BUF_M1_SKEW_EN
      test_skew();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
